demux_dispatch_ctrl: RTL and testbench

//  Sequences the 1-to-2 data demux: buffers tagged 32-bit words from one producer and

---
 rtl/dispatch_pkg.sv | 18 +
 rtl/dispatch_fifo.sv | 69 ++++++
 rtl/demux_dispatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared definitions for the demux dispatch controller: FSM states, destination codes
// and the occupancy-width helper used by the top and its FIFO.
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        BLOCKED = 2'd2
    } dispatch_state_t;

    localparam logic DEST_0 = 1'b0;
    localparam logic DEST_1 = 1'b1;

    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Tagged-word FIFO for the dispatch controller: power-of-2 depth, wrapping pointers,
// separate occupancy count; flush clears pointers and count and overrides push/pop.
module dispatch_fifo
    import dispatch_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = occ_w(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rptr];
    assign count  = r_count;

    // Storage is not reset: the top gates every data output with head-valid.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// 1-to-2 demux dispatcher: buffers tagged words and presents them in order to out0/out1.
// Optional per-destination pop counters cnt0/cnt1 are built when DEMUX_DISPATCH_STATS_EN is defined.
module demux_dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STALL_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_dest,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [DATA_W-1:0]      out0_data,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [DATA_W-1:0]      out1_data,
    output logic                   cur_sel,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   stall_timeout
`ifdef DEMUX_DISPATCH_STATS_EN
    ,
    output logic [31:0]            cnt0,
    output logic [31:0]            cnt1
`endif
);

    localparam int unsigned CNT_W = occ_w(DEPTH);
    localparam int unsigned SC_W  = $clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_LIMIT);

    dispatch_state_t r_state;
    dispatch_state_t w_state_nxt;
    logic [SC_W-1:0] r_stall_cnt;
    logic [SC_W-1:0] w_stall_nxt;
    logic            r_stall_timeout;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_empties;
    logic [DATA_W:0]   w_rdata;
    logic [CNT_W-1:0]  w_count;
    logic              w_head_dest;

    assign w_push    = in_valid && !w_full;
    assign w_empties = w_pop && (w_count == CNT_W'(1)) && !w_push;
    assign in_ready  = !w_full;
    assign occupancy = w_count;
    assign stall_timeout = r_stall_timeout;

    dispatch_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({in_dest, in_data}),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_nxt;
            if (flush) begin
                r_stall_timeout <= 1'b0;
            end else if (w_stall_nxt == STALL_MAX) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    // IDLE can already pop its only word; staying in IDLE then avoids SEND with an empty FIFO.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_cnt;
        case (r_state)
            IDLE: begin
                if (w_count != '0 && !w_empties) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_pop) begin
                    if (w_empties) begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = BLOCKED;
                    w_stall_nxt = SC_W'(1);
                end
            end
            BLOCKED: begin
                if (w_pop) begin
                    w_state_nxt = w_empties ? IDLE : SEND;
                    w_stall_nxt = '0;
                end else if (r_stall_cnt != STALL_MAX) begin
                    w_stall_nxt = r_stall_cnt + SC_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_stall_nxt = '0;
            end
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_stall_nxt = '0;
        end
    end

    always_comb begin
        w_head_dest = w_rdata[DATA_W];
        out0_valid  = !w_empty && (w_head_dest == DEST_0);
        out1_valid  = !w_empty && (w_head_dest == DEST_1);
        out0_data   = out0_valid ? w_rdata[DATA_W-1:0] : '0;
        out1_data   = out1_valid ? w_rdata[DATA_W-1:0] : '0;
        cur_sel     = w_empty ? DEST_0 : w_head_dest;
        w_pop       = (out0_valid && out0_ready) || (out1_valid && out1_ready);
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [31:0] r_cnt0;
    logic [31:0] r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (flush) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                r_cnt0 <= r_cnt0 + 32'd1;
            end
            if (out1_valid && out1_ready) begin
                r_cnt1 <= r_cnt1 + 32'd1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl; the stats scenario is included when
// DEMUX_DISPATCH_STATS_EN is defined for both bench and design.
module tb_demux_dispatch_ctrl;
    import dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_dest = 1'b0;
    logic        out0_ready = 1'b0;
    logic        out1_ready = 1'b0;
    logic        in_ready;
    logic        out0_valid;
    logic        out1_valid;
    logic [31:0] out0_data;
    logic [31:0] out1_data;
    logic        cur_sel;
    logic [2:0]  occupancy;
    logic        stall_timeout;
`ifdef DEMUX_DISPATCH_STATS_EN
    logic [31:0] cnt0;
    logic [31:0] cnt1;
`endif

    typedef struct packed {
        logic        dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    demux_dispatch_ctrl #(
        .DATA_W      (32),
        .DEPTH       (4),
        .STALL_LIMIT (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_dest       (in_dest),
        .out0_valid    (out0_valid),
        .out0_ready    (out0_ready),
        .out0_data     (out0_data),
        .out1_valid    (out1_valid),
        .out1_ready    (out1_ready),
        .out1_data     (out1_data),
        .cur_sel       (cur_sel),
        .occupancy     (occupancy),
        .stall_timeout (stall_timeout)
`ifdef DEMUX_DISPATCH_STATS_EN
        ,
        .cnt0          (cnt0),
        .cnt1          (cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Consumer side of the scoreboard: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            vectors++;
            if ((out0_valid && out1_valid) !== 1'b0) begin
                miscompares++;
                $display("FAIL onehot: out0_valid=%b out1_valid=%b both high", out0_valid, out1_valid);
            end
            if ((out0_valid && out0_ready) || (out1_valid && out1_ready)) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got dest=%b data0=%h data1=%h, required no transfer",
                             cur_sel, out0_data, out1_data);
                end else begin
                    mon_e = sb.pop_front();
                    if ({out1_valid, out0_valid, out0_data, out1_data} !==
                        {mon_e.dest, !mon_e.dest, (mon_e.dest ? 32'd0 : mon_e.data),
                         (mon_e.dest ? mon_e.data : 32'd0)}) begin
                        miscompares++;
                        $display("FAIL pop_word: got v1=%b v0=%b d0=%h d1=%h, required dest=%b data=%h",
                                 out1_valid, out0_valid, out0_data, out1_data, mon_e.dest, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({in_ready, out0_valid, out1_valid, cur_sel, stall_timeout, occupancy, out0_data, out1_data}
            !== {1'b1, 4'b0000, 3'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_por: got rdy=%b v0=%b v1=%b sel=%b to=%b occ=%0d, required rdy=1 rest 0",
                     in_ready, out0_valid, out1_valid, cur_sel, stall_timeout, occupancy);
        end
        step();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h1111_1111;
        in_dest = 1'b0;
        step();
        in_data = 32'h2222_2222;
        in_dest = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (occupancy !== 3'd2) begin
            miscompares++;
            $display("FAIL reset_prefill: occupancy=%0d required 2", occupancy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out0_valid, out1_valid, cur_sel, stall_timeout, occupancy, out0_data, out1_data}
            !== {1'b1, 4'b0000, 3'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: got rdy=%b v0=%b v1=%b sel=%b occ=%0d d0=%h, required rdy=1 rest 0",
                     in_ready, out0_valid, out1_valid, cur_sel, occupancy, out0_data);
        end
        vectors++;
        if (dut.r_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d required IDLE", dut.r_state);
        end
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (occupancy !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_discard: occupancy=%0d required 0", occupancy);
        end
    endtask

    task automatic test_order();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hA5A5_A5A5;
        in_dest = 1'b0;
        sb.push_back('{dest: 1'b0, data: 32'hA5A5_A5A5});
        vectors++;
        if ({out0_valid, out1_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL order_nobypass: v0=%b v1=%b required 00", out0_valid, out1_valid);
        end
        step();
        vectors++;
        if ({out0_valid, out1_valid, out0_data, out1_data, occupancy} !== {2'b10, 32'hA5A5_A5A5, 32'd0, 3'd1}) begin
            miscompares++;
            $display("FAIL order_first: v0=%b v1=%b d0=%h d1=%h occ=%0d required 10 a5a5a5a5 0 1",
                     out0_valid, out1_valid, out0_data, out1_data, occupancy);
        end
        in_data = 32'h1234_5678;
        in_dest = 1'b1;
        sb.push_back('{dest: 1'b1, data: 32'h1234_5678});
        step();
        in_valid = 1'b0;
        vectors++;
        if ({out0_valid, out1_valid, out0_data, out1_data, cur_sel} !== {2'b01, 32'd0, 32'h1234_5678, 1'b1}) begin
            miscompares++;
            $display("FAIL order_second: v0=%b v1=%b d0=%h d1=%h sel=%b required 01 0 12345678 1",
                     out0_valid, out1_valid, out0_data, out1_data, cur_sel);
        end
        step();
        vectors++;
        if ({occupancy, out1_valid, sb.size() == 0} !== {3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL order_done: occ=%0d v1=%b pending=%0d required 0 0 0", occupancy, out1_valid, sb.size());
        end
    endtask

    task automatic test_full();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 32'hF000_0000 + i;
            in_dest = i[0];
            vectors++;
            if (in_ready !== (i < 4)) begin
                miscompares++;
                $display("FAIL full_ready%0d: in_ready=%b required %b", i, in_ready, (i < 4));
            end
            if (i < 4) sb.push_back('{dest: i[0], data: 32'hF000_0000 + i});
            step();
            vectors++;
            if (occupancy !== 3'((i < 4) ? i + 1 : 4)) begin
                miscompares++;
                $display("FAIL full_occ%0d: occupancy=%0d required %0d", i, occupancy, (i < 4) ? i + 1 : 4);
            end
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pushpop_ready: in_ready=%b required 0", in_ready);
        end
        step();
        vectors++;
        if ({occupancy, in_ready} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL full_poponly: occ=%0d rdy=%b required 3 1", occupancy, in_ready);
        end
        sb.push_back('{dest: 1'b0, data: 32'hF000_0004});
        step();
        in_valid = 1'b0;
        vectors++;
        if (occupancy !== 3'd3) begin
            miscompares++;
            $display("FAIL full_pushpop: occupancy=%0d required 3", occupancy);
        end
        for (int i = 0; i < 20 && occupancy != 3'd0; i++) step();
        vectors++;
        if ({occupancy, sb.size() == 0} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL full_drain: occ=%0d pending=%0d required 0 0", occupancy, sb.size());
        end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b1;
        out1_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        in_dest = 1'b1;
        sb.push_back('{dest: 1'b1, data: 32'hDEAD_BEEF});
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            vectors++;
            if ({out1_valid, out0_valid, out1_data, occupancy, stall_timeout} !==
                {2'b10, 32'hDEAD_BEEF, 3'd1, (k >= 16)}) begin
                miscompares++;
                $display("FAIL stall_k%0d: v1=%b v0=%b d1=%h occ=%0d to=%b required 1 0 deadbeef 1 %b",
                         k, out1_valid, out0_valid, out1_data, occupancy, stall_timeout, (k >= 16));
            end
        end
        out1_ready = 1'b1;
        step();
        out1_ready = 1'b0;
        out0_ready = 1'b0;
        vectors++;
        if ({occupancy, stall_timeout, sb.size() == 0} !== {3'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_sticky: occ=%0d to=%b pending=%0d required 0 1 0", occupancy, stall_timeout, sb.size());
        end
    endtask

    task automatic test_flush();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 32'hC0DE_0000 + i;
            in_dest = ~i[0];
            step();
        end
        vectors++;
        if ({occupancy, stall_timeout} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_pre: occ=%0d to=%b required 3 1", occupancy, stall_timeout);
        end
        in_data = 32'hC0DE_0003;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        vectors++;
        if ({occupancy, stall_timeout, out0_valid, out1_valid, dut.r_state == IDLE} !== {3'd0, 3'b000, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_clear: occ=%0d to=%b v0=%b v1=%b state=%0d required 0 0 0 0 IDLE",
                     occupancy, stall_timeout, out0_valid, out1_valid, dut.r_state);
        end
        step();
        vectors++;
        if (occupancy !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_hold: occupancy=%0d required 0", occupancy);
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h0BAD_F00D;
        in_dest = 1'b0;
        sb.push_back('{dest: 1'b0, data: 32'h0BAD_F00D});
        step();
        in_valid = 1'b0;
        step();
        vectors++;
        if ({occupancy, sb.size() == 0} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush_after: occ=%0d pending=%0d required 0 0", occupancy, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        t;
        for (int c = 0; c < 40; c++) begin
            d = $urandom;
            t = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_data = d;
            in_dest = t;
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) sb.push_back('{dest: t, data: d});
            step();
        end
        in_valid = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 20 && occupancy != 3'd0; i++) step();
        vectors++;
        if ({occupancy, sb.size() == 0} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_drain: occ=%0d pending=%0d required 0 0", occupancy, sb.size());
        end
    endtask

`ifdef DEMUX_DISPATCH_STATS_EN
    task automatic test_stats();
        logic [4:0] dests;
        dests = 5'b10100;
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if ({cnt0, cnt1} !== 64'd0) begin
            miscompares++;
            $display("FAIL stats_clear0: cnt0=%0d cnt1=%0d required 0 0", cnt0, cnt1);
        end
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 32'h5757_0000 + i;
            in_dest = dests[i];
            sb.push_back('{dest: dests[i], data: 32'h5757_0000 + i});
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && occupancy != 3'd0; i++) step();
        vectors++;
        if ({cnt0, cnt1, occupancy} !== {32'd3, 32'd2, 3'd0}) begin
            miscompares++;
            $display("FAIL stats_count: cnt0=%0d cnt1=%0d occ=%0d required 3 2 0", cnt0, cnt1, occupancy);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if ({cnt0, cnt1} !== 64'd0) begin
            miscompares++;
            $display("FAIL stats_flush: cnt0=%0d cnt1=%0d required 0 0", cnt0, cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_order();
        test_full();
        test_backpressure();
        test_flush();
        test_back_to_back();
`ifdef DEMUX_DISPATCH_STATS_EN
        test_stats();
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
